// File: rtl/br_resolve.sv
// Branch resolution in EX: compares the actual outcome against the carried BTB prediction.
// On a mispredict it waits for the delay slot, then pulses flush/redirect and the BTB update.
`ifndef BR_WD
`define BR_WD 33
`endif

module br_resolve #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [31:0]       ex_pc,
    input  logic              ex_br_taken,
    input  logic [31:0]       ex_br_target,
    input  logic              ex_bp_e,
    input  logic [31:0]       ex_bp_target,
    input  logic              stall,
    input  logic              ds_valid,
    input  logic              pipe_flush,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic [`BR_WD-1:0] br_bus,
    output logic [31:0]       delayslot_pc,
    output logic              busy,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DS = 2'd1,
        FIRE    = 2'd2
    } state_t;

    state_t      state;
    logic        br_e;
    logic [31:0] br_target;
    logic        pend_upd;

    logic        accept;
    logic        hit;
    logic        miss_t;
    logic        miss_nt;
    logic [31:0] pc_p4;
    logic [31:0] pc_p8;

    assign accept  = ex_valid & ex_is_branch & ~stall & ~pipe_flush & (state == IDLE);
    assign hit     = ex_br_taken & ex_bp_e & (ex_bp_target == ex_br_target);
    assign miss_t  = ex_br_taken & ~hit;
    assign miss_nt = ~ex_br_taken & ex_bp_e;
    assign pc_p4   = ex_pc + 32'd4;
    assign pc_p8   = ex_pc + 32'd8;

    assign br_bus  = {br_e, br_target};
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            flush        <= 1'b0;
            br_e         <= 1'b0;
            br_target    <= 32'd0;
            redirect_pc  <= 32'd0;
            delayslot_pc <= 32'd0;
            pend_upd     <= 1'b0;
            br_cnt       <= '0;
            miss_cnt     <= '0;
        end else begin
            flush <= 1'b0;
            br_e  <= 1'b0;
            if (pipe_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (br_cnt != '1)
                                br_cnt <= br_cnt + 1'b1;
                            if (miss_t || miss_nt) begin
                                if (miss_cnt != '1)
                                    miss_cnt <= miss_cnt + 1'b1;
                                redirect_pc <= miss_t ? ex_br_target : pc_p8;
                                pend_upd    <= miss_t;
                                // BTB has no invalidate, so only a taken miss rewrites the entry
                                if (miss_t) begin
                                    br_target    <= ex_br_target;
                                    delayslot_pc <= pc_p4;
                                end
                                if (ds_valid) begin
                                    state <= FIRE;
                                    flush <= 1'b1;
                                    br_e  <= miss_t;
                                end else begin
                                    state <= WAIT_DS;
                                end
                            end
                        end
                    end
                    WAIT_DS: begin
                        if (ds_valid && !stall) begin
                            state <= FIRE;
                            flush <= 1'b1;
                            br_e  <= pend_upd;
                        end
                    end
                    FIRE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: hits, misses, delay-slot wait, pipe_flush, saturation, async reset.
`ifndef BR_WD
`define BR_WD 33
`endif

module tb_br_resolve;

    logic              clk;
    logic              resetn;
    logic              ex_valid;
    logic              ex_is_branch;
    logic [31:0]       ex_pc;
    logic              ex_br_taken;
    logic [31:0]       ex_br_target;
    logic              ex_bp_e;
    logic [31:0]       ex_bp_target;
    logic              stall;
    logic              ds_valid;
    logic              pipe_flush;

    logic              flush;
    logic [31:0]       redirect_pc;
    logic [`BR_WD-1:0] br_bus;
    logic [31:0]       delayslot_pc;
    logic              busy;
    logic [15:0]       br_cnt;
    logic [15:0]       miss_cnt;

    logic              flush4;
    logic [31:0]       redirect_pc4;
    logic [`BR_WD-1:0] br_bus4;
    logic [31:0]       delayslot_pc4;
    logic              busy4;
    logic [3:0]        br_cnt4;
    logic [3:0]        miss_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    br_resolve #(.CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_bp_e(ex_bp_e), .ex_bp_target(ex_bp_target), .stall(stall),
        .ds_valid(ds_valid), .pipe_flush(pipe_flush), .flush(flush),
        .redirect_pc(redirect_pc), .br_bus(br_bus), .delayslot_pc(delayslot_pc),
        .busy(busy), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    br_resolve #(.CNT_W(4)) dut4 (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pc(ex_pc), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_bp_e(ex_bp_e), .ex_bp_target(ex_bp_target), .stall(stall),
        .ds_valid(ds_valid), .pipe_flush(pipe_flush), .flush(flush4),
        .redirect_pc(redirect_pc4), .br_bus(br_bus4), .delayslot_pc(delayslot_pc4),
        .busy(busy4), .br_cnt(br_cnt4), .miss_cnt(miss_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                              input logic bpe, input logic [31:0] bpt, input logic ds);
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_pc        = pc;
        ex_br_taken  = taken;
        ex_br_target = tgt;
        ex_bp_e      = bpe;
        ex_bp_target = bpt;
        ds_valid     = ds;
    endtask

    task automatic clear_branch();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ex_valid = 0; ex_is_branch = 0; ex_pc = 0; ex_br_taken = 0;
        ex_br_target = 0; ex_bp_e = 0; ex_bp_target = 0; stall = 0; ds_valid = 0; pipe_flush = 0;
        step();
        step();
        n_cmp++;
        if ({flush, br_bus, redirect_pc, delayslot_pc, busy, br_cnt, miss_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs flush=%b br_bus=%h redir=%h ds_pc=%h busy=%b br=%0d miss=%0d expected all zero",
                     flush, br_bus, redirect_pc, delayslot_pc, busy, br_cnt, miss_cnt);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_correct_taken();
        set_branch(32'h1000, 1, 32'h2000, 1, 32'h2000, 1);
        step();
        clear_branch();
        n_cmp++;
        if ({flush, br_bus[32], busy} !== 3'b000) begin
            n_err++; $display("FAIL hit_no_flush flush=%b br_e=%b busy=%b expected 000", flush, br_bus[32], busy);
        end
        n_cmp++;
        if (br_cnt !== 16'd1 || miss_cnt !== 16'd0) begin
            n_err++; $display("FAIL hit_counters br=%0d miss=%0d expected 1/0", br_cnt, miss_cnt);
        end
        step();
    endtask

    task automatic test_cold_taken();
        set_branch(32'h1000, 1, 32'h2000, 0, 32'h0, 1);
        step();
        clear_branch();
        n_cmp++;
        if (flush !== 1'b1 || br_bus[32] !== 1'b1 || redirect_pc !== 32'h2000) begin
            n_err++; $display("FAIL cold_fire flush=%b br_e=%b redir=%h expected 1 1 00002000", flush, br_bus[32], redirect_pc);
        end
        n_cmp++;
        if (br_bus[31:0] !== 32'h2000 || delayslot_pc !== 32'h1004) begin
            n_err++; $display("FAIL cold_btb br_target=%h ds_pc=%h expected 00002000 00001004", br_bus[31:0], delayslot_pc);
        end
        n_cmp++;
        if (br_cnt !== 16'd2 || miss_cnt !== 16'd1) begin
            n_err++; $display("FAIL cold_counters br=%0d miss=%0d expected 2/1", br_cnt, miss_cnt);
        end
        step();
        n_cmp++;
        if ({flush, br_bus[32], busy} !== 3'b000) begin
            n_err++; $display("FAIL cold_one_pulse flush=%b br_e=%b busy=%b expected 000", flush, br_bus[32], busy);
        end
    endtask

    task automatic test_wait_ds();
        set_branch(32'h1000, 1, 32'h2000, 1, 32'h3000, 0);
        step();
        clear_branch();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || flush !== 1'b0 || br_bus[32] !== 1'b0) begin
                n_err++; $display("FAIL wait_busy[%0d] busy=%b flush=%b br_e=%b expected 1 0 0", i, busy, flush, br_bus[32]);
            end
            if (i == 2) ds_valid = 1'b1;
            step();
        end
        ds_valid = 1'b0;
        n_cmp++;
        if (flush !== 1'b1 || br_bus[32] !== 1'b1 || redirect_pc !== 32'h2000) begin
            n_err++; $display("FAIL wait_fire flush=%b br_e=%b redir=%h expected 1 1 00002000", flush, br_bus[32], redirect_pc);
        end
        step();
        n_cmp++;
        if ({flush, br_bus[32], busy} !== 3'b000) begin
            n_err++; $display("FAIL wait_done flush=%b br_e=%b busy=%b expected 000", flush, br_bus[32], busy);
        end
    endtask

    task automatic test_miss_nt_wrap();
        set_branch(32'hFFFF_FFFC, 0, 32'h5000, 1, 32'h5000, 1);
        step();
        clear_branch();
        n_cmp++;
        if (flush !== 1'b1 || br_bus[32] !== 1'b0 || redirect_pc !== 32'h0000_0004) begin
            n_err++; $display("FAIL nt_fire flush=%b br_e=%b redir=%h expected 1 0 00000004", flush, br_bus[32], redirect_pc);
        end
        n_cmp++;
        if (br_bus[31:0] !== 32'h2000 || delayslot_pc !== 32'h1004) begin
            n_err++; $display("FAIL nt_btb_hold br_target=%h ds_pc=%h expected 00002000 00001004", br_bus[31:0], delayslot_pc);
        end
        step();
        n_cmp++;
        if (br_cnt !== 16'd4 || miss_cnt !== 16'd3) begin
            n_err++; $display("FAIL nt_counters br=%0d miss=%0d expected 4/3", br_cnt, miss_cnt);
        end
    endtask

    task automatic test_stall_pipe_flush();
        set_branch(32'h1100, 1, 32'h2200, 1, 32'h2200, 1);
        stall = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (br_cnt !== 16'd4) begin
            n_err++; $display("FAIL stall_hold br=%0d expected 4", br_cnt);
        end
        stall = 1'b0;
        step();
        clear_branch();
        n_cmp++;
        if (br_cnt !== 16'd5 || miss_cnt !== 16'd3) begin
            n_err++; $display("FAIL stall_once br=%0d miss=%0d expected 5/3", br_cnt, miss_cnt);
        end
        set_branch(32'h1200, 1, 32'h2400, 0, 32'h0, 0);
        step();
        clear_branch();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL pf_wait busy=%b expected 1", busy);
        end
        ds_valid   = 1'b1;
        pipe_flush = 1'b1;
        step();
        pipe_flush = 1'b0;
        ds_valid   = 1'b0;
        n_cmp++;
        if ({flush, br_bus[32], busy} !== 3'b000) begin
            n_err++; $display("FAIL pf_drop flush=%b br_e=%b busy=%b expected 000", flush, br_bus[32], busy);
        end
        step();
        n_cmp++;
        if ({flush, br_bus[32], busy} !== 3'b000) begin
            n_err++; $display("FAIL pf_drop_late flush=%b br_e=%b busy=%b expected 000", flush, br_bus[32], busy);
        end
        set_branch(32'h1300, 1, 32'h2600, 0, 32'h0, 1);
        pipe_flush = 1'b1;
        step();
        clear_branch();
        pipe_flush = 1'b0;
        n_cmp++;
        if (flush !== 1'b0 || busy !== 1'b0 || br_cnt !== 16'd6 || miss_cnt !== 16'd4) begin
            n_err++; $display("FAIL pf_accept flush=%b busy=%b br=%0d miss=%0d expected 0 0 6 4", flush, busy, br_cnt, miss_cnt);
        end
        step();
    endtask

    task automatic test_saturation_reset();
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            set_branch(32'h4000 + 32'(i * 16), 1, 32'h8000, 0, 32'h0, 1);
            step();
            clear_branch();
            step();
        end
        n_cmp++;
        if (miss_cnt4 !== 4'hF || br_cnt4 !== 4'hF) begin
            n_err++; $display("FAIL sat4 miss=%h br=%h expected F/F", miss_cnt4, br_cnt4);
        end
        n_cmp++;
        if (miss_cnt !== 16'd17) begin
            n_err++; $display("FAIL sat16_no_clip miss=%0d expected 17", miss_cnt);
        end
        set_branch(32'h5000, 1, 32'h9000, 0, 32'h0, 1);
        step();
        clear_branch();
        n_cmp++;
        if (flush4 !== 1'b1 || br_bus4[32] !== 1'b1) begin
            n_err++; $display("FAIL rst_prefire flush=%b br_e=%b expected 1 1", flush4, br_bus4[32]);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (flush4 !== 1'b0 || br_bus4[32] !== 1'b0 || miss_cnt4 !== 4'h0 || br_cnt4 !== 4'h0 || busy4 !== 1'b0) begin
            n_err++; $display("FAIL rst_async flush=%b br_e=%b miss=%h br=%h busy=%b expected all 0",
                              flush4, br_bus4[32], miss_cnt4, br_cnt4, busy4);
        end
        resetn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_cold_taken();
        test_wait_ds();
        test_miss_nt_wrap();
        test_stall_pipe_flush();
        test_saturation_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
